// File: rtl/alu_const_pkg.sv
// Shared ALU operation codes, used by every unit that borrows the EX-stage ALU.
package alu_const_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
endpackage

// File: rtl/alu_mult_seq_pkg.sv
// Multiply sequencer constants: FSM state encodings and iteration count.
package alu_mult_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } mult_state_t;

  localparam int MULT_ITERS = 32;
endpackage

// File: rtl/alu_mult_seq_abs_neg.sv
// Conditional two's-complement: passes val through, or negates it when neg is set.
module mult_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/alu_mult_seq.sv
// Iterative shift-add 32x32 multiplier that borrows the shared EX-stage ALU
// for every partial-product addition via a req/gnt handshake.
module alu_mult_seq
  import alu_const_pkg::*;
  import alu_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic             alu_inverse_set,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cf
);

  mult_state_t      state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mult_reg, mult_next;
  logic             neg_reg, neg_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] prod_hi_reg, prod_hi_next;
  logic [WIDTH-1:0] prod_lo_reg, prod_lo_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             fin_reg, fin_next;

  logic [WIDTH-1:0]   op_in  [2];
  logic [WIDTH-1:0]   op_mag [2];
  logic [2*WIDTH-1:0] prod_fix;

  assign op_in[0] = op_a;
  assign op_in[1] = op_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mag
      mult_abs_neg #(.W(WIDTH)) u_abs (
        .val (op_in[gi]),
        .neg (is_signed & op_in[gi][WIDTH-1]),
        .res (op_mag[gi])
      );
    end
  endgenerate

  mult_abs_neg #(.W(2*WIDTH)) u_fix (
    .val ({hi_reg, lo_reg}),
    .neg (neg_reg),
    .res (prod_fix)
  );

  assign alu_req         = (state_reg == ITER) & lo_reg[0];
  assign alu_a           = alu_req ? hi_reg : '0;
  assign alu_b           = alu_req ? mcand_reg : '0;
  assign alu_ctrl        = ALU_ADD;
  assign alu_inverse_set = 1'b0;

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign prod_hi = prod_hi_reg;
  assign prod_lo = prod_lo_reg;

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mult_next    = mult_reg;
    neg_next     = neg_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    cnt_next     = cnt_reg;
    prod_hi_next = prod_hi_reg;
    prod_lo_next = prod_lo_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    fin_next     = fin_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          mcand_next = op_mag[0];
          mult_next  = op_mag[1];
          neg_next   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          busy_next  = 1'b1;
          state_next = PREP;
        end
      end
      PREP: begin
        hi_next    = '0;
        lo_next    = mult_reg;
        cnt_next   = '0;
        state_next = ITER;
      end
      ITER: begin
        // A set multiplier bit needs the ALU; without a grant the step simply waits.
        if (!lo_reg[0] || alu_gnt) begin
          if (lo_reg[0]) begin
            hi_next = {alu_cf, alu_res[WIDTH-1:1]};
            lo_next = {alu_res[0], lo_reg[WIDTH-1:1]};
          end else begin
            hi_next = {1'b0, hi_reg[WIDTH-1:1]};
            lo_next = {hi_reg[0], lo_reg[WIDTH-1:1]};
          end
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(MULT_ITERS - 1)) begin
            state_next = FIX;
          end
        end
      end
      FIX: begin
        // First FIX cycle registers the sign-corrected product; the second releases done.
        if (!fin_reg) begin
          prod_hi_next = prod_fix[2*WIDTH-1:WIDTH];
          prod_lo_next = prod_fix[WIDTH-1:0];
          fin_next     = 1'b1;
        end else begin
          fin_next   = 1'b0;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      mult_reg    <= '0;
      neg_reg     <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      cnt_reg     <= '0;
      prod_hi_reg <= '0;
      prod_lo_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      fin_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      mult_reg    <= mult_next;
      neg_reg     <= neg_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      cnt_reg     <= cnt_next;
      prod_hi_reg <= prod_hi_next;
      prod_lo_reg <= prod_lo_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      fin_reg     <= fin_next;
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq with a behavioural ALU and grant control.
module tb_alu_mult_seq;
  import alu_const_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, alu_gnt;
  logic [31:0] op_a, op_b;
  logic        busy, done, alu_req, alu_inverse_set, alu_cf;
  logic [31:0] prod_hi, prod_lo, alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctrl;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign {alu_cf, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .alu_req(alu_req),
    .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_inverse_set(alu_inverse_set), .alu_res(alu_res), .alu_cf(alu_cf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int stall_at, input int stall_len, input bit restart);
    int k, req_cnt, exp_req;
    bit busy_ok, alu_ok;
    logic [31:0] mb;
    logic [63:0] got, e;
    mb      = (s && b[31]) ? (~b + 32'd1) : b;
    exp_req = $countones(mb) + stall_len;
    exp_q.push_back(model(a, b, s));
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = ~s;
    k = 0; req_cnt = 0; busy_ok = 1'b1; alu_ok = 1'b1;
    while (k < 200) begin
      alu_gnt = !(k >= stall_at && k < stall_at + stall_len);
      #1;
      if (alu_req) req_cnt++;
      if (!alu_req && (alu_a != 0 || alu_b != 0)) alu_ok = 1'b0;
      if (alu_ctrl != ALU_ADD || alu_inverse_set) alu_ok = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (restart && k == 5) begin
        start = 1'b1; op_a = 32'h0000_0009; op_b = 32'h0000_0009;
      end
      if (restart && k == 6) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    alu_gnt = 1'b1;
    got = {prod_hi, prod_lo};
    e   = exp_q.pop_front();
    check("latency", 64'(k), 64'(35 + stall_len));
    check("prod", got, e);
    check("busy_during", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("alu_req_cycles", 64'(req_cnt), 64'(exp_req));
    check("alu_drive", 64'(alu_ok), 64'd1);
    $display("op a=%h b=%h signed=%0d prod=%h exp=%h latency=%0d req=%0d",
             a, b, s, got, e, k, req_cnt);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("prod_hold", {prod_hi, prod_lo}, e);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0; alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", {prod_hi, prod_lo}, 64'd0);
    check("rst_req", 64'(alu_req), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h0000_0003, 32'h0000_0005, 1'b0, 0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0);
    run_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 0, 0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 1'b0);
    run_op(32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 10, 10, 1'b0);
    run_op(32'h1234_5678, 32'h0000_0000, 1'b0, 0, 0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'h0000_1234, 1'b1, 0, 0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, 1'(i[0]), 0, 0, 1'b0);
    end

    // Reset in the middle of ITER must abort cleanly with no done.
    op_a = 32'h0000_0055; op_b = 32'hFFFF_FFFF; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_prod", {prod_hi, prod_lo}, 64'd0);
    check("midrst_req", 64'(alu_req), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("midrst_quiet", 64'(seen_done), 64'd0);
    $display("op reset mid-ITER busy=%0d done=%0d prod=%h", busy, done, {prod_hi, prod_lo});

    run_op(32'h0001_0001, 32'h0000_FFFF, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Iterative 32x32 multiply sequencer for the DLX EX stage, executing MULT and MULTU.
- It does not contain an adder. Every partial-product addition is done on the shared 32-bit ALU, driven as an ADD operation.
- It requests the ALU from the EX-stage mux with a req/gnt handshake and stalls while the ALU is not granted.
- The result is a registered 64-bit product; the pipeline control waits on busy/done.

Parameters:
- WIDTH, 32, operand width; fixed to the ALU width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  accept a new operation; sampled only in IDLE
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- op_a  in  WIDTH  multiplicand; sampled with start
- op_b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; prod_hi/prod_lo are valid in that cycle
- prod_hi  out  WIDTH  upper product word; held until the next accepted start
- prod_lo  out  WIDTH  lower product word; held until the next accepted start
- alu_req  out  1  request for the shared ALU in the current cycle
- alu_gnt  in  1  ALU granted this cycle; same-cycle combinational response
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_ctrl  out  4  ALU operation code
- alu_inverse_set  out  1  ALU inverse_set input
- alu_res  in  WIDTH  ALU result
- alu_cf  in  1  ALU carry-out

Behaviour:
- Reset: state=IDLE; busy=0, done=0, prod_hi=0, prod_lo=0, alu_req=0, counter=0, sign flag=0.
- ALU drive: alu_ctrl is always ALU_ADD (4'b0100) and alu_inverse_set is always 0. alu_a=hi and alu_b=mcand while alu_req=1; both are 0 otherwise.
- State IDLE, on start=1:
  - latch mcand=|op_a| and mult=|op_b|. Magnitudes apply only if is_signed; the conversion is local logic, not the ALU.
  - latch neg = is_signed & (op_a[31]^op_b[31]).
  - go to PREP.
- State PREP (1 cycle): hi=0, lo=mult, cnt=0; go to ITER.
- State ITER, one bit per step:
  - alu_req = lo[0].
  - Step advances when lo[0]=0, or when lo[0]=1 and alu_gnt=1.
  - Advance with add: {hi,lo} <= {alu_cf, alu_res, lo[31:1]}.
  - Advance without add: {hi,lo} <= {1'b0, hi, lo[31:1]}.
  - Every advance: cnt++.
  - lo[0]=1 and alu_gnt=0: hold all state (stall); alu_req stays 1.
  - After the advance with cnt=WIDTH-1, go to FIX.
- State FIX (1 cycle):
  - {prod_hi,prod_lo} <= neg ? (~{hi,lo} + 1) : {hi,lo}.
  - done=1 in the following cycle, together with the state returning to IDLE.
  - busy drops in that same cycle.
- Latency with no stalls: start sampled at edge N; done high in the cycle after edge N+35.
  - Breakdown: PREP 1, ITER 32, FIX 1, plus register.
  - Every stalled cycle adds exactly 1.
- Boundary cases:
  - start while busy: ignored, no effect.
  - start held high in IDLE after done: a new operation begins and prod is overwritten at its FIX.
  - op_b=0: alu_req never asserts; latency is unchanged.
  - Signed 0x80000000: its magnitude is 0x80000000 as an unsigned value; the result is correct without special-casing.
  - rst mid-operation: next cycle is IDLE with all outputs at reset values; no done; alu_req=0.
  - alu_gnt while alu_req=0: ignored.

Decomposition:
- ALU op codes come from the shared alu_const header (ALU_ADD etc.); do not redefine them locally.
- Add a mult_const header holding the state encodings (IDLE/PREP/ITER/FIX, 2 bits) and MULT_ITERS=32.
- One natural sub-module: mult_abs_neg. It is combinational and does conditional two's-complement magnitude/negate.
  - Instantiated twice at 32 bits for the operands.
  - Instantiated once at 64 bits for the product.

Test Plan:
- Unsigned 3*5, alu_gnt tied 1: prod_hi=0, prod_lo=0000000F; done exactly 35 cycles after start; busy high throughout.
- Unsigned FFFFFFFF*FFFFFFFF: prod_hi=FFFFFFFE, prod_lo=00000001 (exercises the alu_cf path); alu_req high on all 32 ITER cycles.
- Signed cases:
  - -2*3 (FFFFFFFE*00000003) -> prod_hi=FFFFFFFF, prod_lo=FFFFFFFA.
  - 80000000*80000000 -> prod_hi=40000000, prod_lo=00000000.
- Stall: unsigned 7*FFFFFFFF with alu_gnt=0 for 10 cycles mid-ITER -> alu_req stays 1 and state holds; done at cycle 45; prod_hi=00000006, prod_lo=FFFFFFF9.
- op_b=0 with op_a=12345678: alu_req never 1; done at 35; prod=0.
- Reset and busy handling:
  - start pulsed again while busy: ignored, first result unaffected.
  - rst asserted at ITER step 10: next cycle busy=0, done=0, prod=0, alu_req=0.
  - a new start after reset completes normally.
